// File: rtl/reg_file_pkg.sv
// Shared types, default geometry and depth helper for the parametrised
// two-read/one-write register file.
package reg_file_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Number of entries addressed by an addr_w-bit register index
  function automatic int rf_depth(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_init_ctrl.sv
// Post-reset clear sequencer: walks every entry once, one per cycle, and
// holds the core off with init_busy until the last entry is cleared.
module rf_init_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(rf_depth(ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};

  rf_state_t         state_r;
  rf_state_t         state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;

  // State and sweep counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state: one entry per cycle, leave INIT on the edge that clears the last
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_INIT;
          cnt_nxt_s   = cnt_r + ADDR_W'(1'b1);
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Storage is left alone on a reset edge, so the clear strobe is masked by rst
  assign init_busy = (state_r == ST_INIT);
  assign clr_en    = (state_r == ST_INIT) && !rst;
  assign clr_addr  = cnt_r;

endmodule

// File: rtl/reg_file_bypass.sv
// Decode-stage register file: two combinational read ports with optional
// same-cycle write forwarding, one write-back port, optional hardwired R0.
module reg_file_bypass
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              init_busy
);

  localparam int                DEPTH     = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              init_busy_s;
  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_drop_s;
  logic              port_wr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [DATA_W-1:0] rd_data_s [2];

  rf_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy_s),
    .clr_en    (clr_en_s),
    .clr_addr  (clr_addr_s)
  );

  assign init_busy = init_busy_s;

  // Write mux: the clear sweep owns the array; port writes are dropped, never queued
  always_comb begin
    wr_drop_s   = (ZERO_REG0 == 1'b1) && (wr_addr == ADDR_ZERO);
    port_wr_s   = wr_en && !init_busy_s && !wr_drop_s;
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
    if (clr_en_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = DATA_ZERO;
    end else if (port_wr_s && !rst) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end
  end

  // Storage array, single write per cycle, no reset of contents
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign rd_addr_s[0] = rd_addr1;
  assign rd_addr_s[1] = rd_addr2;

  // Per-port read mux: zero while sweeping, hardwired R0, forwarded write, then storage
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = DATA_ZERO;
      if (init_busy_s) begin
        rd_data_s[p] = DATA_ZERO;
      end else if ((ZERO_REG0 == 1'b1) && (rd_addr_s[p] == ADDR_ZERO)) begin
        rd_data_s[p] = DATA_ZERO;
      end else if ((BYPASS == 1'b1) && port_wr_s && (wr_addr == rd_addr_s[p])) begin
        rd_data_s[p] = wr_data;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
      end
    end
  end

  assign rd_data1 = rd_data_s[0];
  assign rd_data2 = rd_data_s[1];

endmodule
